tdc_channel_scheduler: RTL

Sequences repeated time-to-digital measurements across N_CH pulse sources that share one time counter and one pulse counter. Selects channels round-robin and runs a clear/measure cycle per measurement. Averages 2^AVG_LOG2 measurements per channel and presents one result per channel on a valid/ready output. Sits between the per-channel edge detectors (single-cycle pulse_in) and the readout/host interface.

---
 rtl/tdc_pkg.sv | 25 ++
 rtl/tdc_rr_picker.sv | 37 +++
 rtl/tdc_channel_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC channel scheduler slice.
//   tdc_state_e  : scheduler FSM states
//   ch_bits_of   : width of a channel index for a given channel count
//   acc_bits_of  : accumulator width that cannot overflow when summing
//                  2^avg_log2 samples of time_bits each
package tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CLEAR,
    S_MEASURE,
    S_ACCUM,
    S_OUTPUT
  } tdc_state_e;

  function automatic int ch_bits_of(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int acc_bits_of(input int time_bits, input int avg_log2);
    return time_bits + avg_log2;
  endfunction

endpackage

// File: rtl/tdc_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   mask      : channel enable mask
//   last      : last-serviced channel; the search starts strictly after it
//   next_ch   : first set mask bit after last, wrapping around
//   any_valid : high when mask has at least one bit set
module tdc_rr_picker
  import tdc_pkg::*;
#(
  parameter int  N_CH    = 4,
  localparam int CH_BITS = ch_bits_of(N_CH)
)(
  input  logic [N_CH-1:0]    mask,
  input  logic [CH_BITS-1:0] last,
  output logic [CH_BITS-1:0] next_ch,
  output logic               any_valid
);

  always_comb begin
    int                 idx;
    logic [CH_BITS-1:0] cand;
    next_ch   = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    // i runs 1..N_CH so the last-serviced channel itself is tried last.
    for (int i = 1; i <= N_CH; i++) begin
      idx  = (int'(last) + i) % N_CH;
      cand = CH_BITS'(idx);
      if (!any_valid && mask[cand]) begin
        next_ch   = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_channel_scheduler.sv
// Round-robin scheduler for repeated time-to-digital measurements across
// N_CH pulse sources sharing one time counter and one pulse counter.
// Each selected channel gets 2^AVG_LOG2 clear/measure runs; the averaged
// time is presented on a valid/ready result port.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : allows a new channel set to start
//   ch_mask      : channel enable mask, sampled in SELECT
//   pulse_in     : single-cycle pulses, one bit per channel
//   sel_ch       : channel owning the counters (valid while busy)
//   clear        : high during the one-cycle CLEAR state
//   busy         : high in every state except IDLE
//   res_valid, res_ready, res_data, res_ch, res_timeout : result port
// Result handshake: res_valid stays high and res_data/res_ch/res_timeout
// stay stable until a cycle with res_valid && res_ready; that cycle is the
// transfer and res_valid drops on the following cycle.
// The FSM state is held in the signal `state` for observation.
module tdc_channel_scheduler
  import tdc_pkg::*;
#(
  parameter int  N_CH            = 4,
  parameter int  COUNT_TIME_BITS = 16,
  parameter int  PULSE_TARGET    = 10,
  parameter int  TIMEOUT_CYCLES  = 65535,
  parameter int  AVG_LOG2        = 2,
  localparam int CH_BITS         = ch_bits_of(N_CH)
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_CH-1:0]            ch_mask,
  input  logic [N_CH-1:0]            pulse_in,
  output logic [CH_BITS-1:0]         sel_ch,
  output logic                       clear,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [COUNT_TIME_BITS-1:0] res_data,
  output logic [CH_BITS-1:0]         res_ch,
  output logic                       res_timeout
);

  localparam int ACC_BITS = acc_bits_of(COUNT_TIME_BITS, AVG_LOG2);
  localparam int RUN_BITS = AVG_LOG2 + 1;
  localparam int RUNS     = 1 << AVG_LOG2;
  localparam int PC_BITS  = $clog2(PULSE_TARGET + 1);
  localparam logic [COUNT_TIME_BITS-1:0] RES_ONES = '1;

  tdc_state_e state, state_next;

  logic [CH_BITS-1:0]         last_ch;
  logic [CH_BITS-1:0]         pick_ch;
  logic                       pick_valid;
  logic [ACC_BITS-1:0]        acc;
  logic [ACC_BITS-1:0]        acc_next;
  logic [RUN_BITS-1:0]        run_cnt;
  logic [RUN_BITS-1:0]        run_next;
  logic [COUNT_TIME_BITS-1:0] time_cnt;
  logic [COUNT_TIME_BITS-1:0] time_cur;
  logic [PC_BITS-1:0]         pulse_cnt;
  logic [PC_BITS-1:0]         pulse_cur;
  logic [COUNT_TIME_BITS-1:0] sample;
  logic                       to_flag;
  logic                       hit;
  logic                       expire;
  logic                       last_run;
  logic                       want_start;

  tdc_rr_picker #(.N_CH(N_CH)) u_picker (
    .mask      (ch_mask),
    .last      (last_ch),
    .next_ch   (pick_ch),
    .any_valid (pick_valid)
  );

  // Values "in this cycle" during MEASURE: the first MEASURE cycle reads 1.
  assign time_cur   = time_cnt + COUNT_TIME_BITS'(1);
  assign pulse_cur  = pulse_cnt + PC_BITS'(pulse_in[sel_ch]);
  assign hit        = (pulse_cur == PC_BITS'(PULSE_TARGET));
  assign expire     = (time_cur == COUNT_TIME_BITS'(TIMEOUT_CYCLES));
  assign acc_next   = acc + ACC_BITS'(sample);
  assign run_next   = run_cnt + RUN_BITS'(1);
  assign last_run   = (run_next == RUN_BITS'(RUNS));
  assign want_start = enable && (|ch_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    busy       = 1'b1;
    res_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (want_start) state_next = S_SELECT;
      end
      // The mask may have emptied since the IDLE decision; fall back to IDLE.
      S_SELECT:  state_next = pick_valid ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        clear      = 1'b1;
        state_next = S_MEASURE;
      end
      S_MEASURE: if (hit || expire) state_next = S_ACCUM;
      S_ACCUM:   state_next = last_run ? S_OUTPUT : S_CLEAR;
      S_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = want_start ? S_SELECT : S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Reset value of last_ch makes the first search begin at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ch     <= CH_BITS'(N_CH - 1);
      sel_ch      <= '0;
      acc         <= '0;
      run_cnt     <= '0;
      time_cnt    <= '0;
      pulse_cnt   <= '0;
      sample      <= '0;
      to_flag     <= 1'b0;
      res_data    <= '0;
      res_ch      <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        S_SELECT: begin
          if (pick_valid) sel_ch <= pick_ch;
          acc     <= '0;
          run_cnt <= '0;
          to_flag <= 1'b0;
        end
        S_CLEAR: begin
          time_cnt  <= '0;
          pulse_cnt <= '0;
        end
        S_MEASURE: begin
          time_cnt  <= time_cur;
          pulse_cnt <= pulse_cur;
          // Completion takes priority over a timeout in the same cycle.
          if (hit) begin
            sample <= time_cur;
          end else if (expire) begin
            sample  <= RES_ONES;
            to_flag <= 1'b1;
          end
        end
        S_ACCUM: begin
          acc     <= acc_next;
          run_cnt <= run_next;
          if (last_run) begin
            res_data    <= to_flag ? RES_ONES
                                   : COUNT_TIME_BITS'(acc_next >> AVG_LOG2);
            res_ch      <= sel_ch;
            res_timeout <= to_flag;
          end
        end
        S_OUTPUT: if (res_ready) last_ch <= sel_ch;
        default: ;
      endcase
    end
  end

endmodule
